block_position_ctrl: RTL and testbench
======================================

# block_position_ctrl

Parametrised successor to the block position loader for the stacker game. It drives the moving block's x/y coordinates and pixel colour into the VGA datapath. It adds a configurable step, configurable bounds, a move-rate divider, a place handshake with level counting, and top-of-screen detection. It sits between the control FSM (which issues `ld_x` and `place` strobes) and the datapath/plot logic.

## Interface
- `X_W`, 8: width of x coordinate
- `Y_W`, 7: width of y coordinate and of `level`
- `STEP`, 4: pixels moved per step, both horizontal and vertical
- `X_MAX`, 156: rightmost legal x; must be a multiple of `STEP`
- `Y_START`, 116: y after reset (bottom row)
- `Y_MIN`, 0: lowest legal y (top row)
- `DIV_INIT`, 4: number of `ld_x` strobes per horizontal step; must be ≥1
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `ld_x` in 1: move strobe, one cycle per frame tick
- `place` in 1: drop request, one-cycle pulse
- `colour_in` in 3: block colour
- `colour_erase_enable` in 1: force black for erase pass
- `x` out `X_W`: current block x
- `y` out `Y_W`: current block y
- `colour` out 3: pixel colour
- `level` out `Y_W`: rows placed
- `place_ack` out 1: one-cycle pulse when a placement is accepted
- `top_reached` out 1: sticky, game-over row reached

## Operation
- Reset values: `x`=0, direction=right, `y`=`Y_START`, `level`=0, divider count=0, period=`DIV_INIT`, `place_ack`=0, `top_reached`=0, state=MOVE.
- FSM states:
  - MOVE: normal operation.
  - DONE: terminal; exited only by `reset`.
- Divider, in MOVE: each `ld_x` increments the count. When the count equals period−1, the count clears and x steps.
- Bounce rule:
  - Moving right with `x`==`X_MAX`: direction flips to left and `x` becomes `X_MAX`−`STEP`.
  - Moving left with `x`==0: direction flips to right and `x` becomes `STEP`.
  - Otherwise `x` moves ±`STEP`.
  - `x` never leaves [0, `X_MAX`].
- Place, in MOVE with `place`=1:
  - `place_ack`=1 for one cycle and `level` increments.
  - Divider count clears; `x` and direction are held.
  - If `y` ≥ `Y_MIN`+`STEP`: `y` becomes `y`−`STEP`.
  - Otherwise `y` is held, `top_reached` becomes 1 and the FSM goes to DONE.
- Simultaneous `place` and `ld_x`: place wins; no horizontal step and no divider increment that cycle.
- DONE: `ld_x` and `place` are ignored; `x`, `y`, `level` hold; `top_reached` stays 1; `place_ack` stays 0.
- `colour` is combinational: 3'b000 when `colour_erase_enable`=1, else `colour_in`. It is independent of state and reset.
- Level saturates at 2^`Y_W`−1 (unreachable with the default parameters).

## Timing
- All state is registered on rising `clk`. `x`, `y`, `level` and `top_reached` update at the edge that samples the strobe, so they are visible the following cycle.
- `place_ack` is registered and high exactly the cycle after `place` was sampled.
- Move latency is `DIV_INIT` `ld_x` strobes per step. Strobes need not be consecutive.
- `reset` asserted mid-operation, including in DONE or during `place`, overrides everything at the next edge.

## Configuration
- `BLOCK_SPEEDUP_EN` defined: on every accepted place, period becomes max(1, `DIV_INIT`−`level_new`), so the block speeds up each row.
- Not defined: period is constant `DIV_INIT` and the speedup logic is absent.

## Structure
- Shared package `stacker_pkg` holds:
  - the state enum (MOVE, DONE);
  - the direction encoding (RIGHT=1, LEFT=0);
  - the default geometry constants (`X_MAX`, `Y_START`, `STEP`).
- One sub-module, `move_divider`. Inputs: `clk`, `reset`, `ld_x`, `clear`, `period`. Output: `step` pulse.

## Test plan
- `DIV_INIT`=1, 39 `ld_x` pulses from reset → `x`=156; next pulse → `x`=152 with direction left; 38 more pulses → `x`=0; next pulse → `x`=4.
- `DIV_INIT`=4, 7 `ld_x` pulses → `x`=4 (step on the 4th); 8th pulse → `x`=8.
- `place` pulse at reset state → next cycle `y`=112, `level`=1, `place_ack`=1 for one cycle, `x` unchanged.
- 29 places → `y`=0; 30th place → `top_reached`=1, `y`=0, `level`=30; further `ld_x`/`place` → no change; `reset` → all reset values.
- `place` and `ld_x` in the same cycle with the count at period−1 → no x step, count=0, `y` decremented.
- `BLOCK_SPEEDUP_EN`, `DIV_INIT`=4: after 1 place the period is 3; after 3 or more places the period is 1 (every `ld_x` steps). Separately, check `colour_erase_enable`=1 → `colour`=0 regardless of `colour_in`.

Source files
------------

// File: rtl/block_position_ctrl_pkg.sv
// stacker_pkg: types and default geometry shared by the stacker block-position
// logic and its sub-modules.
//   state_t : controller FSM states (MOVE, DONE)
//   dir_t   : horizontal direction encoding (RIGHT=1, LEFT=0)
//   *_DEF   : default screen geometry (X_MAX, Y_START, STEP)
package stacker_pkg;

  typedef enum logic {
    MOVE = 1'b0,
    DONE = 1'b1
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  localparam int X_MAX_DEF   = 156;
  localparam int Y_START_DEF = 116;
  localparam int STEP_DEF    = 4;

endpackage

// File: rtl/block_position_ctrl_if.sv
// block_position_ctrl_if: bundle between the control FSM / datapath (master)
// and the block position controller (slave).
//   master drives : ld_x, place, colour_in, colour_erase_enable
//   slave drives  : x, y, colour, level, place_ack, top_reached
interface block_position_ctrl_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           ld_x;
  logic           place;
  logic [2:0]     colour_in;
  logic           colour_erase_enable;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic [Y_W-1:0] level;
  logic           place_ack;
  logic           top_reached;

  modport master (
    output ld_x, place, colour_in, colour_erase_enable,
    input  x, y, colour, level, place_ack, top_reached
  );

  modport slave (
    input  ld_x, place, colour_in, colour_erase_enable,
    output x, y, colour, level, place_ack, top_reached
  );
endinterface

// File: rtl/block_position_ctrl_move_divider.sv
// move_divider: counts move strobes and emits a step pulse on the strobe that
// completes a period.
//   clk, reset : clock, synchronous active-high reset
//   ld_x       : move strobe (already qualified by the caller)
//   clear      : restart the count; suppresses any step this cycle
//   period     : strobes per step, must be >= 1
//   step       : combinational pulse, high with the strobe that wraps the count
module move_divider #(
  parameter int P_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ld_x,
  input  logic           clear,
  input  logic [P_W-1:0] period,
  output logic           step
);

  logic [P_W-1:0] r_count;
  logic           w_wrap;

  // >= rather than == so a shrinking period can never strand the count above it
  assign w_wrap = (r_count >= (period - P_W'(1)));
  assign step   = ld_x & ~clear & w_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (ld_x) begin
      r_count <= w_wrap ? '0 : r_count + P_W'(1);
    end
  end

endmodule

// File: rtl/block_position_ctrl.sv
// block_position_ctrl: moving-block position, colour and placement tracking
// for the stacker game.
//   clk, reset : clock, synchronous active-high reset
//   bus        : block_position_ctrl_if.slave (strobes in; x/y/colour/level/
//                place_ack/top_reached out)
// Optional build macro BLOCK_SPEEDUP_EN: each accepted place shortens the move
// period to max(1, DIV_INIT - level).
module block_position_ctrl
  import stacker_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int STEP     = STEP_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_START  = Y_START_DEF,
  parameter int Y_MIN    = 0,
  parameter int DIV_INIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  block_position_ctrl_if.slave bus
);

  localparam int P_W = $clog2(DIV_INIT + 1);

  localparam logic [X_W-1:0] L_STEP_X  = X_W'(STEP);
  localparam logic [X_W-1:0] L_X_MAX   = X_W'(X_MAX);
  localparam logic [Y_W-1:0] L_STEP_Y  = Y_W'(STEP);
  localparam logic [Y_W-1:0] L_Y_START = Y_W'(Y_START);
  localparam logic [Y_W-1:0] L_Y_THR   = Y_W'(Y_MIN + STEP);

  state_t         r_state, w_state_nxt;
  dir_t           r_dir,   w_dir_nxt;
  logic [X_W-1:0] r_x,     w_x_nxt;
  logic [Y_W-1:0] r_y,     w_y_nxt;
  logic [Y_W-1:0] r_level, w_level_nxt;
  logic           r_ack,   w_ack_nxt;
  logic           r_top,   w_top_nxt;

  logic           w_move;
  logic           w_clear;
  logic           w_ld;
  logic           w_step;
  logic [P_W-1:0] w_period;

`ifdef BLOCK_SPEEDUP_EN
  logic [P_W-1:0] r_period, w_period_nxt;
  assign w_period = r_period;
`else
  assign w_period = P_W'(DIV_INIT);
`endif

  // Place has priority over a coincident move strobe.
  assign w_move  = (r_state == MOVE);
  assign w_clear = w_move & bus.place;
  assign w_ld    = w_move & bus.ld_x & ~bus.place;

  move_divider #(
    .P_W (P_W)
  ) u_move_divider (
    .clk    (clk),
    .reset  (reset),
    .ld_x   (w_ld),
    .clear  (w_clear),
    .period (w_period),
    .step   (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_level_nxt = r_level;
    w_ack_nxt   = 1'b0;
    w_top_nxt   = r_top;
`ifdef BLOCK_SPEEDUP_EN
    w_period_nxt = r_period;
`endif
    case (r_state)
      MOVE: begin
        if (bus.place) begin
          w_ack_nxt = 1'b1;
          if (r_level != '1) begin
            w_level_nxt = r_level + Y_W'(1);
          end
          if (r_y >= L_Y_THR) begin
            w_y_nxt = r_y - L_STEP_Y;
          end else begin
            w_top_nxt   = 1'b1;
            w_state_nxt = DONE;
          end
`ifdef BLOCK_SPEEDUP_EN
          if (int'(w_level_nxt) >= DIV_INIT - 1) begin
            w_period_nxt = P_W'(1);
          end else begin
            w_period_nxt = P_W'(DIV_INIT - int'(w_level_nxt));
          end
`endif
        end else if (w_step) begin
          if (r_dir == RIGHT) begin
            if (r_x >= L_X_MAX) begin
              w_dir_nxt = LEFT;
              w_x_nxt   = L_X_MAX - L_STEP_X;
            end else begin
              w_x_nxt   = r_x + L_STEP_X;
            end
          end else begin
            if (r_x == '0) begin
              w_dir_nxt = RIGHT;
              w_x_nxt   = L_STEP_X;
            end else begin
              w_x_nxt   = r_x - L_STEP_X;
            end
          end
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = MOVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MOVE;
      r_dir   <= RIGHT;
      r_x     <= '0;
      r_y     <= L_Y_START;
      r_level <= '0;
      r_ack   <= 1'b0;
      r_top   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_level <= w_level_nxt;
      r_ack   <= w_ack_nxt;
      r_top   <= w_top_nxt;
    end
  end

`ifdef BLOCK_SPEEDUP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= P_W'(DIV_INIT);
    end else begin
      r_period <= w_period_nxt;
    end
  end
`endif

  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.level       = r_level;
  assign bus.place_ack   = r_ack;
  assign bus.top_reached = r_top;
  assign bus.colour      = bus.colour_erase_enable ? '0 : bus.colour_in;

endmodule

// File: tb/tb_block_position_ctrl.sv
// Directed bench for block_position_ctrl: two instances (DIV_INIT=1 and 4)
// share clock and reset; expected values are hand-computed constants.
module tb_block_position_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  block_position_ctrl_if #(.X_W(8), .Y_W(7)) if_d1 ();
  block_position_ctrl_if #(.X_W(8), .Y_W(7)) if_d4 ();

  block_position_ctrl #(
    .X_W(8), .Y_W(7), .STEP(4), .X_MAX(156), .Y_START(116), .Y_MIN(0), .DIV_INIT(1)
  ) u_d1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_d1.slave)
  );

  block_position_ctrl #(
    .X_W(8), .Y_W(7), .STEP(4), .X_MAX(156), .Y_START(116), .Y_MIN(0), .DIV_INIT(4)
  ) u_d4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_d4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ld1(input int n);
    if_d1.ld_x = 1'b1;
    tick(n);
    if_d1.ld_x = 1'b0;
  endtask

  task automatic ld4(input int n);
    if_d4.ld_x = 1'b1;
    tick(n);
    if_d4.ld_x = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    if_d1.ld_x = 1'b0; if_d1.place = 1'b0;
    if_d1.colour_in = 3'd0; if_d1.colour_erase_enable = 1'b0;
    if_d4.ld_x = 1'b0; if_d4.place = 1'b0;
    if_d4.colour_in = 3'd0; if_d4.colour_erase_enable = 1'b0;
    tick(2);
    reset = 1'b0;

    check_vec("rst_x",     int'(if_d1.x), 0);
    check_vec("rst_y",     int'(if_d1.y), 116);
    check_vec("rst_level", int'(if_d1.level), 0);
    check_vec("rst_ack",   int'(if_d1.place_ack), 0);
    check_vec("rst_top",   int'(if_d1.top_reached), 0);
    check_vec("rst_y_d4",  int'(if_d4.y), 116);

    // place from reset state
    if_d1.place = 1'b1;
    tick(1);
    if_d1.place = 1'b0;
    check_vec("place1_y",     int'(if_d1.y), 112);
    check_vec("place1_level", int'(if_d1.level), 1);
    check_vec("place1_ack",   int'(if_d1.place_ack), 1);
    check_vec("place1_x",     int'(if_d1.x), 0);
    tick(1);
    check_vec("place1_ack_drop", int'(if_d1.place_ack), 0);

    // bounce with DIV_INIT=1
    ld1(39);
    check_vec("d1_right_edge", int'(if_d1.x), 156);
    ld1(1);
    check_vec("d1_bounce_r", int'(if_d1.x), 152);
    ld1(38);
    check_vec("d1_left_edge", int'(if_d1.x), 0);
    ld1(1);
    check_vec("d1_bounce_l", int'(if_d1.x), 4);

    // divider with DIV_INIT=4
    ld4(3);
    check_vec("d4_3", int'(if_d4.x), 0);
    ld4(1);
    check_vec("d4_4", int'(if_d4.x), 4);
    ld4(3);
    check_vec("d4_7", int'(if_d4.x), 4);
    ld4(1);
    check_vec("d4_8", int'(if_d4.x), 8);

    // place + ld_x coincident with count at period-1
    ld4(3);
    if_d4.place = 1'b1;
    if_d4.ld_x  = 1'b1;
    tick(1);
    if_d4.place = 1'b0;
    if_d4.ld_x  = 1'b0;
    check_vec("coinc_x",     int'(if_d4.x), 8);
    check_vec("coinc_y",     int'(if_d4.y), 112);
    check_vec("coinc_level", int'(if_d4.level), 1);
    check_vec("coinc_ack",   int'(if_d4.place_ack), 1);
    tick(1);
    check_vec("coinc_ack_drop", int'(if_d4.place_ack), 0);
`ifdef BLOCK_SPEEDUP_EN
    ld4(2);
    check_vec("cnt_clr_hold", int'(if_d4.x), 8);
    ld4(1);
    check_vec("cnt_clr_step", int'(if_d4.x), 12);
`else
    ld4(3);
    check_vec("cnt_clr_hold", int'(if_d4.x), 8);
    ld4(1);
    check_vec("cnt_clr_step", int'(if_d4.x), 12);
`endif

    // two more places -> level 3
    if_d4.place = 1'b1;
    tick(2);
    if_d4.place = 1'b0;
    check_vec("d4_lvl3_y",     int'(if_d4.y), 104);
    check_vec("d4_lvl3_level", int'(if_d4.level), 3);
    ld4(1);
`ifdef BLOCK_SPEEDUP_EN
    check_vec("speed_1", int'(if_d4.x), 16);
    ld4(3);
    check_vec("speed_4", int'(if_d4.x), 28);
`else
    check_vec("speed_1", int'(if_d4.x), 12);
    ld4(3);
    check_vec("speed_4", int'(if_d4.x), 16);
`endif

    // climb to the top with d1
    if_d1.place = 1'b1;
    tick(28);
    if_d1.place = 1'b0;
    check_vec("top_row_y",     int'(if_d1.y), 0);
    check_vec("top_row_level", int'(if_d1.level), 29);
    check_vec("top_row_flag",  int'(if_d1.top_reached), 0);
    if_d1.place = 1'b1;
    tick(1);
    if_d1.place = 1'b0;
    check_vec("top_flag",  int'(if_d1.top_reached), 1);
    check_vec("top_y",     int'(if_d1.y), 0);
    check_vec("top_level", int'(if_d1.level), 30);
    check_vec("top_ack",   int'(if_d1.place_ack), 1);
    tick(1);
    check_vec("done_ack_drop", int'(if_d1.place_ack), 0);
    ld1(5);
    if_d1.place = 1'b1;
    tick(3);
    if_d1.place = 1'b0;
    check_vec("done_x",     int'(if_d1.x), 4);
    check_vec("done_y",     int'(if_d1.y), 0);
    check_vec("done_level", int'(if_d1.level), 30);
    check_vec("done_ack",   int'(if_d1.place_ack), 0);
    check_vec("done_top",   int'(if_d1.top_reached), 1);

    // colour path
    if_d1.colour_in = 3'b101;
    if_d1.colour_erase_enable = 1'b0;
    #1;
    check_vec("colour_pass", int'(if_d1.colour), 5);
    if_d1.colour_erase_enable = 1'b1;
    #1;
    check_vec("colour_erase5", int'(if_d1.colour), 0);
    if_d1.colour_in = 3'b111;
    #1;
    check_vec("colour_erase7", int'(if_d1.colour), 0);
    if_d1.colour_erase_enable = 1'b0;
    #1;
    check_vec("colour_pass7", int'(if_d1.colour), 7);

    // reset overrides DONE and a concurrent place
    reset = 1'b1;
    if_d1.ld_x  = 1'b1;
    if_d4.place = 1'b1;
    tick(1);
    reset = 1'b0;
    if_d1.ld_x  = 1'b0;
    if_d4.place = 1'b0;
    check_vec("rst2_x",     int'(if_d1.x), 0);
    check_vec("rst2_y",     int'(if_d1.y), 116);
    check_vec("rst2_level", int'(if_d1.level), 0);
    check_vec("rst2_top",   int'(if_d1.top_reached), 0);
    check_vec("rst2_y_d4",  int'(if_d4.y), 116);
    check_vec("rst2_ack_d4", int'(if_d4.place_ack), 0);
    ld1(1);
    check_vec("rst2_moves", int'(if_d1.x), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
